ws2812b_bit_decoder: RTL and testbench
======================================

// Module: ws2812b_bit_decoder
// PURPOSE
//  Front end of the impostor WS2812B receiver. Synchronises the raw serial DIN pin and measures each high pulse.
//  Each valid pulse becomes one (bit_valid, bit_value) strobe, which feeds ws2812b_byte_assembler directly.
//  Also detects the >=50us low "reset/latch" gap, which ends a frame, and flags malformed pulses.
// PARAMETERS
//  THRESH_CYCLES    38    high time >= this decodes as '1', else '0' (0.6us @ 64MHz)
//  MIN_HIGH_CYCLES  6     high pulses shorter than this are glitches (no bit emitted)
//  MAX_HIGH_CYCLES  128   high time reaching this is stuck-high (2us @ 64MHz)
//  RESET_CYCLES     3200  continuous low reaching this is a latch gap (50us @ 64MHz)
//  CNT_W            12    counter width; must hold RESET_CYCLES
// PORTS
//  clk          in   1  single clock; all logic on posedge
//  reset        in   1  synchronous, active-high reset
//  din          in   1  raw asynchronous WS2812B data pin
//  bit_valid    out  1  1-cycle strobe: one decoded bit
//  bit_value    out  1  decoded bit; valid only while bit_valid=1
//  latch_valid  out  1  1-cycle strobe: latch gap seen after >=1 bit in frame
//  err          out  1  1-cycle strobe: glitch or stuck-high pulse
// BEHAVIOUR
//  - Reset: sync flops, din_d, counters, frame_active = 0; state = LOW; all outputs 0 (bit_value 0).
//  - Sync: din passes through 2 flops to din_s; din_d = din_s delayed 1 cycle.
//    rise = ~din_d & din_s; fall = din_d & ~din_s.
//  - Latency: din transition to output strobe = 3 clk edges (2 sync + 1 registered output).
//  - All outputs are registered and default to 0 each cycle; at most one strobe per cycle.
//  - LOW state:
//    * low_cnt increments while din_s=0, saturating at RESET_CYCLES.
//    * On the cycle low_cnt becomes RESET_CYCLES with frame_active=1: latch_valid=1, then frame_active<=0.
//    * A saturated low_cnt never re-fires the latch.
//    * On rise: high_cnt<=1, low_cnt<=0, go to HIGH.
//  - HIGH state:
//    * high_cnt increments while din_s=1.
//    * When high_cnt reaches MAX_HIGH_CYCLES: err=1, go to HIGH_ERR.
//    * On fall with high_cnt < MIN_HIGH_CYCLES: err=1, no bit emitted.
//    * On fall otherwise: bit_valid=1, bit_value=(high_cnt>=THRESH_CYCLES), frame_active<=1.
//    * On every fall: low_cnt<=1, go to LOW.
//  - HIGH_ERR state: no further err while high; on fall go to LOW, no bit, frame_active unchanged.
//  - Boundaries:
//    * high_cnt==THRESH_CYCLES-1 decodes '0'; high_cnt==THRESH_CYCLES decodes '1'.
//    * high_cnt==MIN_HIGH_CYCLES decodes a bit (no err).
//    * A rise on the same cycle low_cnt would reach RESET_CYCLES: no latch (edge wins).
//    * Idle-low line after reset: no latch_valid (frame_active=0).
//  - din high out of reset is seen as a rise (sync flops reset to 0); that pulse is measured normally.
//  - Reset mid-pulse aborts it silently: no bit, no err.
// STRUCTURE
//  - ws2812b_pkg: timing constants above (64MHz defaults) and state encoding {LOW, HIGH, HIGH_ERR}.
//  - Sub-module ws2812b_din_sync: 2-flop synchroniser plus rise/fall detect (outputs din_s, rise, fall).
//  - Top: FSM, high_cnt, low_cnt, frame_active, output registers.
// TESTING
//  1. Reset, then din high 25 cyc / low 55 -> bit_valid strobe with bit_value=0, 3 clk after din falls.
//     Then high 51 / low 29 -> bit_value=1. No err.
//  2. 24 bits GRB 0xA5_3C_FF, then low 3200+ cyc -> 24 strobes MSB-first matching pattern.
//     Exactly one latch_valid, RESET_CYCLES+2 clk after the last falling edge of din.
//  3. High pulses of 37 and 38 cyc -> bit_value 0 and 1.
//     5-cyc pulse -> err only; 6-cyc pulse -> bit_valid, value 0.
//  4. din held high 300 cyc -> single err when high_cnt hits 128; no bit on fall.
//     Next normal pulse decodes correctly.
//  5. After reset with din low for 10000 cyc -> no latch_valid.
//     Bit, then low 3199 cyc, then high -> no latch_valid.
//  6. Assert reset mid-high pulse (cycle 20) -> all outputs 0, no strobe on fall.
//     Next pulse decodes normally.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// Shared timing defaults (64 MHz clock) and decoder state encoding for the
// WS2812B receiver front end.
package ws2812b_pkg;

   localparam int unsigned DEF_THRESH_CYCLES   = 38;
   localparam int unsigned DEF_MIN_HIGH_CYCLES = 6;
   localparam int unsigned DEF_MAX_HIGH_CYCLES = 128;
   localparam int unsigned DEF_RESET_CYCLES    = 3200;
   localparam int unsigned DEF_CNT_W           = 12;

   typedef enum logic [1:0] {
      ST_LOW      = 2'd0,
      ST_HIGH     = 2'd1,
      ST_HIGH_ERR = 2'd2
   } dec_state_e;

endpackage : ws2812b_pkg

// File: rtl/ws2812b_din_sync.sv
// Two-flop synchroniser for the asynchronous DIN pin, plus a one-cycle delayed
// copy used to detect rising and falling edges of the synchronised level.
module ws2812b_din_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic din_i,
   output logic din_s_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic dly_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= din_i;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign din_s_o = sync_q;
   assign rise_o  = ~dly_q &  sync_q;
   assign fall_o  =  dly_q & ~sync_q;

endmodule : ws2812b_din_sync

// File: rtl/ws2812b_bit_decoder.sv
// Measures each synchronised DIN high pulse and turns it into a bit strobe,
// an error strobe (glitch / stuck-high), or a latch strobe after a long low gap.
module ws2812b_bit_decoder
   import ws2812b_pkg::*;
#(
   parameter int unsigned THRESH_CYCLES   = DEF_THRESH_CYCLES,
   parameter int unsigned MIN_HIGH_CYCLES = DEF_MIN_HIGH_CYCLES,
   parameter int unsigned MAX_HIGH_CYCLES = DEF_MAX_HIGH_CYCLES,
   parameter int unsigned RESET_CYCLES    = DEF_RESET_CYCLES,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic bit_valid,
   output logic bit_value,
   output logic latch_valid,
   output logic err
);

   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH_CYCLES);
   localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH_CYCLES);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_HIGH_CYCLES);
   localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(RESET_CYCLES);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   logic din_s;
   logic rise;
   logic fall;

   dec_state_e       state_q;
   logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0] low_cnt_q,  low_cnt_d;
   logic             frame_active_q;
   logic             bit_valid_q;
   logic             bit_value_q;
   logic             latch_valid_q;
   logic             err_q;

   ws2812b_din_sync u_din_sync (
      .clk_i   (clk),
      .rst_i   (reset),
      .din_i   (din),
      .din_s_o (din_s),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   always_comb begin
      high_cnt_d = high_cnt_q + ONE_C;
      low_cnt_d  = low_cnt_q + ONE_C;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_LOW;
         high_cnt_q     <= '0;
         low_cnt_q      <= '0;
         frame_active_q <= 1'b0;
         bit_valid_q    <= 1'b0;
         bit_value_q    <= 1'b0;
         latch_valid_q  <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         bit_valid_q   <= 1'b0;
         bit_value_q   <= 1'b0;
         latch_valid_q <= 1'b0;
         err_q         <= 1'b0;
         case (state_q)
            ST_LOW: begin
               // A rise always takes priority, so a gap cut short on its last cycle never latches.
               if (rise) begin
                  high_cnt_q <= ONE_C;
                  low_cnt_q  <= '0;
                  state_q    <= ST_HIGH;
               end else if (!din_s && (low_cnt_q != RESET_C)) begin
                  low_cnt_q <= low_cnt_d;
                  if ((low_cnt_d == RESET_C) && frame_active_q) begin
                     latch_valid_q  <= 1'b1;
                     frame_active_q <= 1'b0;
                  end
               end
            end
            ST_HIGH: begin
               if (fall) begin
                  low_cnt_q <= ONE_C;
                  state_q   <= ST_LOW;
                  if (high_cnt_q < MIN_C) begin
                     err_q <= 1'b1;
                  end else begin
                     bit_valid_q    <= 1'b1;
                     bit_value_q    <= (high_cnt_q >= THRESH_C);
                     frame_active_q <= 1'b1;
                  end
               end else if (din_s) begin
                  high_cnt_q <= high_cnt_d;
                  if (high_cnt_d == MAX_C) begin
                     err_q   <= 1'b1;
                     state_q <= ST_HIGH_ERR;
                  end
               end
            end
            ST_HIGH_ERR: begin
               if (fall) begin
                  low_cnt_q <= ONE_C;
                  state_q   <= ST_LOW;
               end
            end
            default: state_q <= ST_LOW;
         endcase
      end
   end

   assign bit_valid   = bit_valid_q;
   assign bit_value   = bit_value_q;
   assign latch_valid = latch_valid_q;
   assign err         = err_q;

endmodule : ws2812b_bit_decoder

// File: tb/tb_ws2812b_bit_decoder.sv
// Directed bench for ws2812b_bit_decoder: pulse widths, boundaries, latch gap,
// stuck-high and reset behaviour, with hand-derived expectations.
module tb_ws2812b_bit_decoder;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic din = 1'b0;
   logic bit_valid, bit_value, latch_valid, err;

   int n_checks = 0;
   int n_errors = 0;

   int cyc = 0;
   int chg_cyc = 0;

   // Event log filled by the monitor; sections work on deltas.
   int          mon_bits = 0;
   int          mon_latch = 0;
   int          mon_err = 0;
   int          last_bit_cyc = 0;
   int          last_latch_cyc = 0;
   int          last_err_cyc = 0;
   logic        last_bit_val = 1'b0;
   logic [31:0] bits_sr = '0;

   ws2812b_bit_decoder dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .bit_valid   (bit_valid),
      .bit_value   (bit_value),
      .latch_valid (latch_valid),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (bit_valid) begin
            mon_bits++;
            last_bit_cyc = cyc;
            last_bit_val = bit_value;
            bits_sr = {bits_sr[30:0], bit_value};
         end
         if (latch_valid) begin
            mon_latch++;
            last_latch_cyc = cyc;
         end
         if (err) begin
            mon_err++;
            last_err_cyc = cyc;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive din to v right after an edge; v is sampled by exactly n rising edges.
   task automatic set_din(input logic v, input int n);
      @(posedge clk);
      #1;
      din = v;
      chg_cyc = cyc;
      repeat (n - 1) @(posedge clk);
   endtask

   task automatic pulse(input int hi, input int lo);
      set_din(1'b1, hi);
      set_din(1'b0, lo);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      din   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bit_valid", bit_valid, 0);
      check("rst_bit_value", bit_value, 0);
      check("rst_latch", latch_valid, 0);
      check("rst_err", err, 0);
      reset = 1'b0;
   endtask

   int b0, l0, e0, fall_cyc, rise_cyc;
   logic [23:0] pat;

   initial begin
      // 1: basic 0 and 1 with output latency
      do_reset();
      set_din(1'b0, 5);
      b0 = mon_bits; e0 = mon_err;
      set_din(1'b1, 25);
      set_din(1'b0, 55);
      fall_cyc = chg_cyc;
      check("t1_bits0", mon_bits - b0, 1);
      check("t1_val0", last_bit_val, 0);
      check("t1_latency", last_bit_cyc - fall_cyc, 3);
      pulse(51, 29);
      check("t1_bits1", mon_bits - b0, 2);
      check("t1_val1", last_bit_val, 1);
      check("t1_noerr", mon_err - e0, 0);

      // 2: 24-bit GRB frame followed by latch gap
      do_reset();
      set_din(1'b0, 5);
      b0 = mon_bits; l0 = mon_latch; e0 = mon_err;
      pat = 24'hA53CFF;
      for (int i = 23; i >= 0; i--) begin
         if (pat[i]) pulse(51, 29);
         else        pulse(25, 55);
      end
      fall_cyc = chg_cyc;
      set_din(1'b0, 3300);
      check("t2_nbits", mon_bits - b0, 24);
      check("t2_pattern", bits_sr[23:0], 24'hA53CFF);
      check("t2_nlatch", mon_latch - l0, 1);
      check("t2_latch_time", last_latch_cyc - fall_cyc, 3202);
      check("t2_noerr", mon_err - e0, 0);

      // 3: threshold and glitch boundaries
      do_reset();
      set_din(1'b0, 5);
      b0 = mon_bits; e0 = mon_err;
      pulse(37, 50);
      check("t3_37_val", last_bit_val, 0);
      pulse(38, 50);
      check("t3_38_val", last_bit_val, 1);
      check("t3_bits_2", mon_bits - b0, 2);
      pulse(5, 50);
      check("t3_5_err", mon_err - e0, 1);
      check("t3_5_nobit", mon_bits - b0, 2);
      pulse(6, 50);
      check("t3_6_bit", mon_bits - b0, 3);
      check("t3_6_val", last_bit_val, 0);
      check("t3_6_noerr", mon_err - e0, 1);

      // 4: stuck high, then recovery and the 127/128 edge
      do_reset();
      set_din(1'b0, 5);
      b0 = mon_bits; e0 = mon_err;
      set_din(1'b1, 300);
      rise_cyc = chg_cyc;
      set_din(1'b0, 50);
      check("t4_err_once", mon_err - e0, 1);
      check("t4_err_time", last_err_cyc - rise_cyc, 130);
      check("t4_nobit", mon_bits - b0, 0);
      pulse(51, 29);
      check("t4_recover_bit", mon_bits - b0, 1);
      check("t4_recover_val", last_bit_val, 1);
      pulse(127, 40);
      check("t4_127_bit", mon_bits - b0, 2);
      check("t4_127_val", last_bit_val, 1);
      pulse(128, 40);
      check("t4_128_err", mon_err - e0, 2);
      check("t4_128_nobit", mon_bits - b0, 2);

      // 5: no latch without a bit, no latch on a 3199-cycle gap
      do_reset();
      l0 = mon_latch; b0 = mon_bits;
      set_din(1'b0, 10000);
      check("t5_idle_nolatch", mon_latch - l0, 0);
      pulse(25, 3199);
      pulse(25, 100);
      check("t5_3199_nolatch", mon_latch - l0, 0);
      check("t5_bits", mon_bits - b0, 2);
      set_din(1'b0, 3300);
      check("t5_then_latch", mon_latch - l0, 1);

      // 6: reset in the middle of a high pulse
      do_reset();
      set_din(1'b0, 5);
      b0 = mon_bits; e0 = mon_err;
      set_din(1'b1, 20);
      do_reset();
      set_din(1'b0, 50);
      check("t6_nobit", mon_bits - b0, 0);
      check("t6_noerr", mon_err - e0, 0);
      pulse(25, 55);
      check("t6_next_bit", mon_bits - b0, 1);
      check("t6_next_val", last_bit_val, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_ws2812b_bit_decoder
